// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: segment codes for the
// decoder ({g,f,e,d,c,b,a}, active-high) and digit slot indices.
package seg7_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0    = 7'h3F;
    localparam seg_t SEG_1    = 7'h06;
    localparam seg_t SEG_2    = 7'h5B;
    localparam seg_t SEG_3    = 7'h4F;
    localparam seg_t SEG_4    = 7'h66;
    localparam seg_t SEG_5    = 7'h6D;
    localparam seg_t SEG_6    = 7'h7D;
    localparam seg_t SEG_7    = 7'h07;
    localparam seg_t SEG_8    = 7'h7F;
    localparam seg_t SEG_9    = 7'h6F;
    localparam seg_t SEG_DASH = 7'h40;

    // Slot order: minute units, ten-minutes, hour units, ten-hours.
    localparam logic [1:0] IDX_MU = 2'd0;
    localparam logic [1:0] IDX_MT = 2'd1;
    localparam logic [1:0] IDX_HU = 2'd2;
    localparam logic [1:0] IDX_HT = 2'd3;

    // The colon segment is wired next to the hour-units digit.
    localparam logic [1:0] COLON_IDX = IDX_HU;

endpackage

// File: rtl/seg7_decode.sv
// BCD to 7-segment decoder. Non-BCD codes (10..15) show a dash so a
// corrupted counter value is visible rather than silently wrong.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Pure lookup from digit value to segment pattern.
    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit 7-segment scan driver (hh:mm).
// Each digit slot lasts PRESCALE cycles; the first BLANK cycles of a slot
// keep all digit enables off to avoid ghosting. All digits and the colon
// are captured on the last cycle of a frame, so a frame never mixes old
// and new values. Outputs are registered (one cycle behind the counters).
// Optional build macro SEG7_LZB_EN: blank the ten-hours digit when it is 0.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int PRESCALE = 32,
    parameter int BLANK    = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] dig0_i,
    input  logic [3:0] dig1_i,
    input  logic [3:0] dig2_i,
    input  logic [3:0] dig3_i,
    input  logic       colon_i,
    output logic [6:0] seg_o,
    output logic [3:0] an_o,
    output logic       dp_o
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] PRE_LAST = CW'(PRESCALE - 1);
    localparam logic [CW:0]   BLANK_C  = (CW + 1)'(BLANK);

    logic [CW-1:0]  pre_cnt_q, pre_cnt_d;
    logic [1:0]     idx_q, idx_d;
    logic [3:0][3:0] snap_q, snap_d;
    logic           colon_q, colon_d;
    logic [6:0]     seg_q, seg_d;
    logic [3:0]     an_q, an_d;
    logic           dp_q, dp_d;

    logic           slot_end;
    logic           frame_end;
    logic           in_blank;
    logic           lzb_dark;
    logic [3:0]     cur_digit;
    logic [6:0]     cur_seg;

    assign slot_end  = (pre_cnt_q == PRE_LAST);
    assign frame_end = slot_end && (idx_q == IDX_HT);
    assign in_blank  = ({1'b0, pre_cnt_q} < BLANK_C);
    assign cur_digit = snap_q[idx_q];

`ifdef SEG7_LZB_EN
    assign lzb_dark = (idx_q == IDX_HT) && (snap_q[IDX_HT] == 4'd0);
`else
    assign lzb_dark = 1'b0;
`endif

    seg7_decode u_decode (
        .bcd_i (cur_digit),
        .seg_o (cur_seg)
    );

    // Next-state for scan counters, frame snapshot and output pipeline.
    always_comb begin
        pre_cnt_d = slot_end ? '0 : pre_cnt_q + 1'b1;
        idx_d     = slot_end ? idx_q + 2'd1 : idx_q;

        snap_d    = snap_q;
        colon_d   = colon_q;
        if (frame_end) begin
            snap_d  = {dig3_i, dig2_i, dig1_i, dig0_i};
            colon_d = colon_i;
        end

        an_d  = 4'b0000;
        seg_d = 7'h00;
        dp_d  = 1'b0;
        if (!in_blank && !lzb_dark) begin
            an_d  = 4'b0001 << idx_q;
            seg_d = cur_seg;
            dp_d  = (idx_q == COLON_IDX) ? colon_q : 1'b0;
        end
    end

    // All state registers with synchronous reset to a dark, zeroed display.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_cnt_q <= '0;
            idx_q     <= '0;
            snap_q    <= '0;
            colon_q   <= 1'b0;
            seg_q     <= 7'h00;
            an_q      <= 4'b0000;
            dp_q      <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            colon_q   <= colon_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            dp_q      <= dp_d;
        end
    end

    assign seg_o = seg_q;
    assign an_o  = an_q;
    assign dp_o  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with PRESCALE=4, BLANK=1.
// Expected segment codes are hand-written hex constants.
module tb_seg7_scan_driver;

    logic       clk;
    logic       rst;
    logic [3:0] d0, d1, d2, d3;
    logic       colon;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef SEG7_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    seg7_scan_driver #(.PRESCALE(4), .BLANK(1)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .dig0_i  (d0),
        .dig1_i  (d1),
        .dig2_i  (d2),
        .dig3_i  (d3),
        .colon_i (colon),
        .seg_o   (seg),
        .an_o    (an),
        .dp_o    (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, "_an"},  {4'h0, an}, 8'h00);
        chk({tag, "_seg"}, {1'b0, seg}, 8'h00);
        chk({tag, "_dp"},  {7'h00, dp}, 8'h00);
    endtask

    // Run n cycles from a frame boundary. e0..e3 are the expected segment
    // codes per slot, edp the colon on slot 2, dark3 forces slot 3 dark.
    // If chg is set, the new input values are applied while slot 1 shows.
    task automatic run_frame(input string tag, input int n,
                             input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3,
                             input logic edp, input logic dark3,
                             input logic chg,
                             input logic [3:0] n0, input logic [3:0] n1,
                             input logic [3:0] n2, input logic [3:0] n3,
                             input logic ncol);
        logic [6:0] exp_seg;
        logic [3:0] exp_an;
        logic       exp_dp;
        for (int k = 0; k < n; k++) begin
            int p;
            int i;
            tick();
            p = k % 4;
            i = k / 4;
            exp_an  = 4'b0000;
            exp_seg = 7'h00;
            exp_dp  = 1'b0;
            if (p != 0 && !(i == 3 && dark3)) begin
                exp_an = 4'b0001 << i;
                case (i)
                    0:       exp_seg = e0;
                    1:       exp_seg = e1;
                    2:       exp_seg = e2;
                    default: exp_seg = e3;
                endcase
                exp_dp = (i == 2) ? edp : 1'b0;
            end
            chk($sformatf("%s_k%0d_an", tag, k),  {4'h0, an},  {4'h0, exp_an});
            chk($sformatf("%s_k%0d_seg", tag, k), {1'b0, seg}, {1'b0, exp_seg});
            chk($sformatf("%s_k%0d_dp", tag, k),  {7'h00, dp}, {7'h00, exp_dp});
            chk($sformatf("%s_k%0d_onehot0", tag, k), {7'h00, $onehot0(an)}, 8'h01);
            if (chg && k == 5) begin
                d0 = n0; d1 = n1; d2 = n2; d3 = n3; colon = ncol;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4; colon = 1'b0;

        // Reset held three cycles: display stays dark.
        for (int r = 0; r < 3; r++) begin
            tick();
            chk_dark($sformatf("reset%0d", r));
        end
        rst = 1'b0;

        // Frame 1 shows the reset snapshot 00:00; dig1 moves to 5 mid-frame.
        run_frame("f1", 16, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0, 1'b0,
                  1'b1, 4'd1, 4'd5, 4'd3, 4'd4, 1'b0);
        // Frame 2 uses the values captured at frame-1 end: 1,5,3,4.
        // The input value 2 on dig1 was never captured.
        run_frame("f2", 16, 7'h06, 7'h6D, 7'h4F, 7'h66, 1'b0, 1'b0,
                  1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        // Frame 3: dig1 changes 5->6 while slot 1 shows; also invalid dig2 and colon.
        run_frame("f3", 16, 7'h06, 7'h6D, 7'h4F, 7'h66, 1'b0, 1'b0,
                  1'b1, 4'd1, 4'd6, 4'hC, 4'd4, 1'b1);
        // Frame 4: 7D appears now, dash on slot 2 with colon; load 09:41.
        run_frame("f4", 16, 7'h06, 7'h7D, 7'h40, 7'h66, 1'b1, 1'b0,
                  1'b1, 4'd1, 4'd4, 4'd9, 4'd0, 1'b0);
        // Frame 5: 09:41, ten-hours dark only with leading-zero blanking.
        run_frame("f5", 16, 7'h06, 7'h66, 7'h6F, 7'h3F, 1'b0, LZB,
                  1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        // Frame 6 partial: stop while slot 2 is showing.
        run_frame("f6", 10, 7'h06, 7'h66, 7'h6F, 7'h3F, 1'b0, LZB,
                  1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);

        // Mid-slot reset: dark on the next edge.
        rst = 1'b1;
        tick();
        chk_dark("midrst");
        rst = 1'b0;

        // Scan restarts at slot 0 with a zeroed snapshot.
        run_frame("f7", 16, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0, LZB,
                  1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        // Then the live 09:41 again.
        run_frame("f8", 16, 7'h06, 7'h66, 7'h6F, 7'h3F, 1'b0, LZB,
                  1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Multiplexed 4-digit 7-segment display driver for the watch display (hh:mm).
- Consumes the fully encoded 4-bit BCD digits produced by the minute, ten-minute and hour counters, and decodes each digit to segments.
- Time-multiplexes the digits with one-hot digit enables, inserts anti-ghosting blank gaps, and drives the colon.
- Snapshots all digits once per frame so a frame never shows mixed old/new values.

Parameters:
- PRESCALE, 32: clk_i cycles per digit slot; legal range >= 2.
- BLANK, 2: dead cycles at the start of each slot with all digit enables inactive; legal range 0 <= BLANK < PRESCALE.

Ports:
- clk_i, in, 1: display scan clock.
- rst_i, in, 1: synchronous reset, active-high.
- dig0_i, in, 4: minute units BCD (xx:xm).
- dig1_i, in, 4: ten-minutes BCD (xx:mx).
- dig2_i, in, 4: hour units BCD (xh:xx).
- dig3_i, in, 4: ten-hours BCD (hx:xx).
- colon_i, in, 1: colon on request (level).
- seg_o, out, 7: segments {g,f,e,d,c,b,a}, active-high, registered.
- an_o, out, 4: one-hot digit enable, active-high, registered; an_o[k] selects digit k.
- dp_o, out, 1: decimal point / colon segment, active-high, registered.

Behaviour:
- Reset is synchronous on rst_i=1:
  - pre_cnt=0, idx=0, snapshot digits=0, snapshot colon=0.
  - seg_o=0, an_o=0, dp_o=0.
  - Mid-frame reset aborts the slot; outputs are dark on the next edge.
- Counters:
  - pre_cnt counts 0..PRESCALE-1, then wraps.
  - idx (2 bits) increments when pre_cnt wraps, order 0,1,2,3,0…
  - Frame length is 4*PRESCALE cycles.
- Snapshot:
  - Capture dig0..3_i and colon_i on the cycle where pre_cnt==PRESCALE-1 and idx==3 (last cycle of the frame).
  - The following frame uses the captured values only.
  - Input changes at any other cycle have no effect until the next frame boundary.
- Output pipeline: outputs are registered and reflect the counter values of the previous cycle (1-cycle latency).
- For counters (p, i) in cycle t, outputs in cycle t+1 are:
  - If p < BLANK: an_o=0, seg_o=0, dp_o=0.
  - Else: an_o=1<<i, seg_o=decode(snapshot digit i), dp_o = snapshot colon when i==2, else 0.
- Decode table (hex):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes 10–15 are invalid and display a dash, 40.
- an_o is never multi-hot in any cycle. The one-cycle gap between slots is guaranteed only when BLANK >= 1.
- After reset deasserts, the first frame shows 00:00 with the colon off.
- Inputs from other clock domains are synchronised upstream; this block samples directly.

Optional Feature:
- Macro: SEG7_LZB_EN (leading-zero blanking).
- Defined: when snapshot dig3 == 0, the digit-3 slot behaves as a blank slot for its full duration (an_o=0, seg_o=0). Example: 09:41 displays " 9:41".
- Undefined: digit 3 is always shown, including 0.
- Counters, snapshot timing and frame length are identical in both builds.

Decomposition:
- Package seg7_pkg holds:
  - Segment code constants SEG_0..SEG_9 and SEG_DASH.
  - Digit index constants (IDX_MU=0, IDX_MT=1, IDX_HU=2, IDX_HT=3).
  - Colon digit index constant COLON_IDX=2.
- Sub-module seg7_decode: pure combinational 4-bit BCD to 7-bit segment map, instantiated once after the snapshot mux.
- Scan counters, snapshot and output registers live in seg7_scan_driver.

Test Plan:
- Reset and first frame (PRESCALE=4, BLANK=1):
  - Stimulus: hold rst_i 3 cycles with digits=1,2,3,4, then release.
  - Required: outputs 0 during reset; first frame shows seg 3F on an_o 0001, 0010, 0100, 1000.
  - Required: second frame shows 06, 5B, 4F, 66 (digit0..3).
- Slot timing and blank gap:
  - Check per slot: 1 cycle with an_o=0000, then 3 cycles with an_o one-hot.
  - Required: an_o is never multi-hot; frame period is 16 cycles.
- Tear-free snapshot:
  - Stimulus: change dig1_i from 5 to 6 while idx==1 is being displayed.
  - Required: 6D persists until the frame end; 7D appears only in the next frame.
- Invalid BCD and colon:
  - Stimulus: dig2_i=4'hC, colon_i=1.
  - Required: digit-2 slot shows seg=40, dp_o=1; all other slots show dp_o=0.
- Reset mid-slot:
  - Stimulus: assert rst_i during the idx 2 display.
  - Required: next edge gives an_o=0, seg_o=0; scanning restarts at idx 0 with zeros.
- SEG7_LZB_EN:
  - Stimulus: digits 0,9,4,1 (ht,hu,mt,mu).
  - Required: the digit-3 slot stays fully dark; with the macro off it shows 3F.
